// File: rtl/display_mux.sv
// rtl/display_mux.sv - time-multiplexed dual-digit nibble driver for seven_seg
//
// Alternates two hex digits onto one shared nibble bus and drives two
// active-low anode enables, with a blanking gap between digits to suppress
// ghosting. Frame order: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   digit0     digit for position 0 (asynchronous to clk)
//   digit1     digit for position 1 (asynchronous to clk)
//   digit_out  nibble to seven_seg.digit, loaded on SHOW entry only
//   an         active-low anode enables, an[0] -> position 0
//   frame_tick one-cycle pulse on the first cycle of each SHOW0 visit
module display_mux #(
  parameter int SHOW_CYCLES  = 23520,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [3:0] digit_out,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  // cnt only ever reaches MAX_CYCLES-1, so $clog2 of the dwell is enough.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       digit_nxt;
  logic             tick_nxt;
  logic             dwell_done;

  logic [3:0] s0a;
  logic [3:0] s0b;
  logic [3:0] s1a;
  logic [3:0] s1b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      digit_out  <= 4'h0;
      frame_tick <= 1'b0;
      s0a        <= 4'h0;
      s0b        <= 4'h0;
      s1a        <= 4'h0;
      s1b        <= 4'h0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_out  <= digit_nxt;
      frame_tick <= tick_nxt;
      s0a        <= digit0;
      s0b        <= s0a;
      s1a        <= digit1;
      s1b        <= s1a;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    digit_nxt = digit_out;
    tick_nxt  = 1'b0;

    if ((state == SHOW0) || (state == SHOW1)) begin
      dwell_done = (cnt == SHOW_LAST);
    end else begin
      dwell_done = (cnt == BLANK_LAST);
    end

    if (dwell_done) begin
      cnt_nxt = '0;
      case (state)
        SHOW0:   state_nxt = BLANK0;
        BLANK0: begin
          state_nxt = SHOW1;
          digit_nxt = s1b;
        end
        SHOW1:   state_nxt = BLANK1;
        default: begin
          // Leaving BLANK1 starts a new frame: load digit 0 and flag it.
          state_nxt = SHOW0;
          digit_nxt = s0b;
          tick_nxt  = 1'b1;
        end
      endcase
    end
  end

  // Decoded purely from the state register, so 2'b00 is unreachable.
  always_comb begin
    case (state)
      SHOW0:   an = 2'b10;
      SHOW1:   an = 2'b01;
      default: an = 2'b11;
    endcase
  end

endmodule
